// File: rtl/ifid_fetch_queue_if.sv
// Fetch-to-decode queue bundle: IF enqueue side, ID dequeue side, redirect flush
// and the pre-split decode fields of the head entry.
interface ifid_fetch_queue_if #(
  parameter int XLEN  = 32,
  parameter int ILEN  = 32,
  parameter int DEPTH = 4
);
  localparam int CNTW = $clog2(DEPTH + 1);

  logic            flush;
  logic            enq_valid;
  logic            enq_ready;
  logic [XLEN-1:0] enq_pc;
  logic [ILEN-1:0] enq_instr;
  logic            deq_valid;
  logic            deq_ready;
  logic [XLEN-1:0] deq_pc;
  logic [ILEN-1:0] deq_instr;
  logic [6:0]      opcode;
  logic [4:0]      rd;
  logic [2:0]      funct3;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [6:0]      funct7;
  logic [11:0]     csr_addr;
  logic [CNTW-1:0] count;

  modport master (
    output flush, enq_valid, enq_pc, enq_instr, deq_ready,
    input  enq_ready, deq_valid, deq_pc, deq_instr, opcode, rd, funct3,
           rs1, rs2, funct7, csr_addr, count
  );

  modport slave (
    input  flush, enq_valid, enq_pc, enq_instr, deq_ready,
    output enq_ready, deq_valid, deq_pc, deq_instr, opcode, rd, funct3,
           rs1, rs2, funct7, csr_addr, count
  );
endinterface

// File: rtl/ifid_fetch_queue.sv
// DEPTH-entry {pc, instr} FIFO between fetch and decode with redirect flush and
// a zero-gated, pre-split view of the head instruction.
module ifid_fetch_queue #(
  parameter int XLEN  = 32,
  parameter int ILEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  ifid_fetch_queue_if.slave  q
);
  localparam int CNTW = $clog2(DEPTH + 1);
  localparam int PTRW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("ifid_fetch_queue: DEPTH must be a power of two and at least 2");
  end
  if (ILEN != 32) begin : g_bad_ilen
    $error("ifid_fetch_queue: ILEN must be 32 for the decode field split");
  end

  logic [XLEN-1:0] pc_mem_q    [DEPTH];
  logic [ILEN-1:0] instr_mem_q [DEPTH];
  logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            enq_fire, deq_fire, head_vld;
  logic [XLEN-1:0] head_pc;
  logic [ILEN-1:0] head_instr;

  // Full blocks enqueue regardless of deq_ready, so there is no ready loop.
  assign q.enq_ready = (count_q != CNTW'(DEPTH));
  assign head_vld    = (count_q != '0) && !q.flush;
  assign enq_fire    = q.enq_valid && q.enq_ready && !q.flush;
  assign deq_fire    = head_vld && q.deq_ready;

  assign head_pc    = head_vld ? pc_mem_q[rd_ptr_q]    : '0;
  assign head_instr = head_vld ? instr_mem_q[rd_ptr_q] : '0;

  assign q.deq_valid = head_vld;
  assign q.deq_pc    = head_pc;
  assign q.deq_instr = head_instr;
  assign q.opcode    = head_instr[6:0];
  assign q.rd        = head_instr[11:7];
  assign q.funct3    = head_instr[14:12];
  assign q.rs1       = head_instr[19:15];
  assign q.rs2       = head_instr[24:20];
  assign q.funct7    = head_instr[31:25];
  assign q.csr_addr  = head_instr[31:20];
  assign q.count     = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (q.flush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (enq_fire) wr_ptr_d = wr_ptr_q + PTRW'(1);
      if (deq_fire) rd_ptr_d = rd_ptr_q + PTRW'(1);
      case ({enq_fire, deq_fire})
        2'b10:   count_d = count_q + CNTW'(1);
        2'b01:   count_d = count_q - CNTW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is data only; its contents are meaningless until written.
  always_ff @(posedge clk) begin
    if (enq_fire && !reset) begin
      pc_mem_q[wr_ptr_q]    <= q.enq_pc;
      instr_mem_q[wr_ptr_q] <= q.enq_instr;
    end
  end
endmodule

// File: tb/tb_ifid_fetch_queue.sv
// Directed bench for ifid_fetch_queue: a queue-based reference checked every
// cycle, a log of dequeued pcs, and hand-computed literal expectations.
module tb_ifid_fetch_queue;
  localparam int XLEN  = 32;
  localparam int ILEN  = 32;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset;
  bit   chk_en = 1'b0;
  int   n_chk  = 0;
  int   n_fail = 0;

  logic [31:0] model_pc[$];
  logic [31:0] model_in[$];
  logic [31:0] deq_log[$];
  bit          m_deq, m_enq;

  ifid_fetch_queue_if #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH)) bus ();

  ifid_fetch_queue #(.XLEN(XLEN), .ILEN(ILEN), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .q     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: an ordered list of pending entries, updated by the handshake rules.
  always @(posedge clk) begin
    if (reset || bus.flush) begin
      model_pc.delete();
      model_in.delete();
    end else begin
      m_deq = (model_pc.size() != 0) && bus.deq_ready;
      m_enq = bus.enq_valid && (model_pc.size() != DEPTH);
      if (m_deq) begin
        void'(model_pc.pop_front());
        void'(model_in.pop_front());
      end
      if (m_enq) begin
        model_pc.push_back(bus.enq_pc);
        model_in.push_back(bus.enq_instr);
      end
    end
  end

  always @(posedge clk) begin
    if (chk_en && !reset && bus.deq_valid && bus.deq_ready) deq_log.push_back(bus.deq_pc);
  end

  always @(negedge clk) begin
    if (chk_en) begin : cmp
      logic        ev;
      logic [31:0] epc, ein;
      ev  = (model_pc.size() != 0) && !bus.flush;
      epc = ev ? model_pc[0] : 32'h0;
      ein = ev ? model_in[0] : 32'h0;
      check("count",     64'(bus.count),     64'(model_pc.size()));
      check("enq_ready", 64'(bus.enq_ready), 64'(model_pc.size() != DEPTH));
      check("deq_valid", 64'(bus.deq_valid), 64'(ev));
      check("deq_pc",    64'(bus.deq_pc),    64'(epc));
      check("deq_instr", 64'(bus.deq_instr), 64'(ein));
      check("opcode",    64'(bus.opcode),    64'(ein[6:0]));
      check("rd",        64'(bus.rd),        64'(ein[11:7]));
      check("funct3",    64'(bus.funct3),    64'(ein[14:12]));
      check("rs1",       64'(bus.rs1),       64'(ein[19:15]));
      check("rs2",       64'(bus.rs2),       64'(ein[24:20]));
      check("funct7",    64'(bus.funct7),    64'(ein[31:25]));
      check("csr_addr",  64'(bus.csr_addr),  64'(ein[31:20]));
    end
  end

  initial begin : stim
    logic [31:0] exp_log[$];
    bit          saw_300;

    reset         = 1'b1;
    bus.flush     = 1'b0;
    bus.enq_valid = 1'b0;
    bus.enq_pc    = '0;
    bus.enq_instr = '0;
    bus.deq_ready = 1'b0;

    // Reset then idle
    tick();
    chk_en = 1'b1;
    tick();
    reset = 1'b0;
    repeat (3) tick();
    check("idle_count",     64'(bus.count),     64'd0);
    check("idle_enq_ready", 64'(bus.enq_ready), 64'd1);
    check("idle_deq_valid", 64'(bus.deq_valid), 64'd0);
    check("idle_opcode",    64'(bus.opcode),    64'd0);

    // Fill to full
    for (int k = 0; k < 4; k++) begin
      bus.enq_valid = 1'b1;
      bus.enq_pc    = 32'h100 + 32'(4 * k);
      bus.enq_instr = 32'h0050_0093 + (32'(k) << 7);
      tick();
      check("fill_count", 64'(bus.count), 64'(k + 1));
    end
    bus.enq_pc    = 32'h110;
    bus.enq_instr = 32'h0000_0013;
    check("full_enq_ready", 64'(bus.enq_ready), 64'd0);
    check("full_deq_pc",    64'(bus.deq_pc),    64'h100);
    check("full_rs1",       64'(bus.rs1),       64'd0);
    check("full_rd",        64'(bus.rd),        64'd1);
    check("full_opcode",    64'(bus.opcode),    64'h13);
    bus.deq_ready = 1'b1;
    #1;
    check("full_enq_ready_deq", 64'(bus.enq_ready), 64'd0);
    tick();
    check("full_deq_count", 64'(bus.count),  64'd3);
    check("full_next_pc",   64'(bus.deq_pc), 64'h104);
    bus.enq_valid = 1'b0;
    repeat (3) tick();
    check("drained_count", 64'(bus.count), 64'd0);

    // Interleaved traffic across pointer wrap
    for (int k = 0; k < 10; k++) begin
      bus.enq_valid = 1'b1;
      bus.enq_pc    = 32'h200 + 32'(4 * k);
      bus.enq_instr = 32'h0000_0013 + (32'(k) << 15) + (32'(k) << 20);
      bus.deq_ready = (k >= 2);
      tick();
      if (k >= 1) check("steady_count", 64'(bus.count), 64'd2);
    end
    bus.enq_valid = 1'b0;
    bus.deq_ready = 1'b1;
    repeat (2) tick();
    check("wrap_empty", 64'(bus.count), 64'd0);
    bus.deq_ready = 1'b0;

    // Flush with concurrent enqueue
    for (int k = 0; k < 3; k++) begin
      bus.enq_valid = 1'b1;
      bus.enq_pc    = 32'h280 + 32'(4 * k);
      bus.enq_instr = 32'h00A0_0113;
      tick();
    end
    check("pre_flush_count", 64'(bus.count), 64'd3);
    bus.flush     = 1'b1;
    bus.enq_pc    = 32'h300;
    bus.enq_instr = 32'h0010_0093;
    #1;
    check("flush_deq_valid", 64'(bus.deq_valid), 64'd0);
    check("flush_deq_pc",    64'(bus.deq_pc),    64'd0);
    check("flush_instr",     64'(bus.deq_instr), 64'd0);
    check("flush_csr",       64'(bus.csr_addr),  64'd0);
    check("flush_enq_ready", 64'(bus.enq_ready), 64'd1);
    tick();
    bus.flush     = 1'b0;
    bus.enq_valid = 1'b0;
    #1;
    check("post_flush_count", 64'(bus.count),     64'd0);
    check("post_flush_valid", 64'(bus.deq_valid), 64'd0);

    // CSR field split
    bus.enq_valid = 1'b1;
    bus.enq_pc    = 32'h400;
    bus.enq_instr = 32'h3002_9073;
    tick();
    bus.enq_valid = 1'b0;
    check("csr_addr",   64'(bus.csr_addr), 64'h300);
    check("csr_funct3", 64'(bus.funct3),   64'd1);
    check("csr_rs1",    64'(bus.rs1),      64'd5);
    check("csr_opcode", 64'(bus.opcode),   64'h73);
    check("csr_funct7", 64'(bus.funct7),   64'h18);
    bus.deq_ready = 1'b1;
    tick();
    bus.deq_ready = 1'b0;

    // Reset mid-operation
    for (int k = 0; k < 2; k++) begin
      bus.enq_valid = 1'b1;
      bus.enq_pc    = 32'h500 + 32'(4 * k);
      bus.enq_instr = 32'h0030_0193;
      tick();
    end
    check("pre_reset_count", 64'(bus.count), 64'd2);
    bus.enq_pc    = 32'h508;
    bus.deq_ready = 1'b1;
    reset         = 1'b1;
    tick();
    reset         = 1'b0;
    bus.enq_valid = 1'b0;
    bus.deq_ready = 1'b0;
    #1;
    check("rst_count",     64'(bus.count),     64'd0);
    check("rst_deq_valid", 64'(bus.deq_valid), 64'd0);
    bus.enq_valid = 1'b1;
    bus.enq_pc    = 32'h600;
    bus.enq_instr = 32'h0040_0213;
    #1;
    check("no_bypass", 64'(bus.deq_valid), 64'd0);
    tick();
    bus.enq_valid = 1'b0;
    check("rst_head_valid", 64'(bus.deq_valid), 64'd1);
    check("rst_head_pc",    64'(bus.deq_pc),    64'h600);
    bus.deq_ready = 1'b1;
    tick();
    bus.deq_ready = 1'b0;
    tick();

    // Dequeue order over the whole run
    exp_log = '{32'h100, 32'h104, 32'h108, 32'h10C};
    for (int k = 0; k < 10; k++) exp_log.push_back(32'h200 + 32'(4 * k));
    exp_log.push_back(32'h400);
    exp_log.push_back(32'h600);
    check("log_len", 64'(deq_log.size()), 64'(exp_log.size()));
    for (int k = 0; k < exp_log.size(); k++) begin
      if (k < deq_log.size()) check("log_pc", 64'(deq_log[k]), 64'(exp_log[k]));
    end
    saw_300 = 1'b0;
    foreach (deq_log[i]) if (deq_log[i] == 32'h300) saw_300 = 1'b1;
    check("flushed_not_dequeued", 64'(saw_300), 64'd0);

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ifid_fetch_queue.md
Name: ifid_fetch_queue

Overview:
- Parametrised successor to the single-entry IF/ID pipeline register: a DEPTH-entry FIFO of {pc, instruction} between fetch and decode.
- Decouples the IF stage from ID stalls using valid/ready handshakes.
- Supports full flush on redirect (branch, trap, CSR return).
- Presents pre-split decode fields of the head entry. These fields are zeroed whenever no valid head exists or a flush is active.

Parameters:
- XLEN, 32, width of the pc field.
- ILEN, 32, width of the instruction field (must be 32 for the field split).
- DEPTH, 4, number of entries; power of two, at least 2.
- CNTW, $clog2(DEPTH+1), width of the occupancy count (derived, not overridden).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  discard all entries and any same-cycle enqueue.
- enq_valid  in  1  IF presents an entry.
- enq_ready  out  1  queue can accept; equals (count != DEPTH); no dependence on deq_ready.
- enq_pc  in  XLEN  fetched pc.
- enq_instr  in  ILEN  fetched instruction.
- deq_valid  out  1  head entry present; equals (count != 0) && !flush.
- deq_ready  in  1  ID consumes the head this cycle.
- deq_pc  out  XLEN  head pc; 0 when deq_valid=0.
- deq_instr  out  ILEN  head instruction; 0 when deq_valid=0.
- opcode  out  7  deq_instr[6:0].
- rd  out  5  deq_instr[11:7].
- funct3  out  3  deq_instr[14:12].
- rs1  out  5  deq_instr[19:15].
- rs2  out  5  deq_instr[24:20].
- funct7  out  7  deq_instr[31:25].
- csr_addr  out  12  deq_instr[31:20].
- count  out  CNTW  current occupancy, 0..DEPTH.

Behaviour:
- Storage:
  - Circular buffer; wr_ptr and rd_ptr are $clog2(DEPTH) bits wide and wrap naturally (DEPTH-1 -> 0).
  - Separate count register holds occupancy.
- Reset (reset=1 at a posedge):
  - wr_ptr, rd_ptr and count return to 0; storage contents are don't-care.
  - Outputs after the edge: enq_ready=1, deq_valid=0, all data/field outputs 0, count=0.
  - Reset overrides flush and all handshakes; reset mid-stream drops every entry.
- Enqueue fires when enq_valid && enq_ready && !flush: writes entry[wr_ptr], then wr_ptr+1.
- Dequeue fires when deq_valid && deq_ready: rd_ptr+1.
- Count update:
  - +1 on enqueue only.
  - -1 on dequeue only.
  - Unchanged when both fire or neither fires.
- Latency: an entry enqueued at edge N is visible on deq_* after edge N (one cycle). There is no combinational enq->deq bypass, even when empty.
- Full (count=DEPTH):
  - enq_ready=0, even if deq_ready=1 in the same cycle (no full-throughput pass-through, no ready loop).
  - enq_valid is ignored while enq_ready=0; IF must hold its data.
- Empty (count=0):
  - deq_valid=0.
  - deq_pc, deq_instr and all decode fields are 0 (bubble = all-zero, decoded as a NOP by ID).
  - deq_ready is ignored.
- Flush (flush=1 at a posedge):
  - rd_ptr <= wr_ptr and count <= 0.
  - Same-cycle enqueue and dequeue are both suppressed.
  - Combinationally during the flush cycle: deq_valid=0 and all data/field outputs are 0.
  - enq_ready is unaffected by flush.
- Simultaneous enqueue and dequeue with 0 < count < DEPTH: both pointers advance and count is held; order is preserved.
- Decode fields are pure slices of the registered head entry, gated to zero by !deq_valid. They carry no additional pipeline delay.
- DEPTH=1 is not supported; elaboration must fail the parameter check.

Test Plan:
- Reset then idle:
  - Stimulus: reset=1 for 2 cycles, then enq_valid=0.
  - Required: count=0, enq_ready=1, deq_valid=0, opcode=0, deq_pc=0 on every cycle.
- Fill to full:
  - Stimulus: enqueue pc 0x100/0x104/0x108/0x10C with instr 0x00500093 etc., deq_ready=0.
  - Required: count steps 1..4; enq_ready=0 after the 4th edge; deq_pc=0x100, rs1=0, rd=1, opcode=0x13.
  - Then with enq_valid=1 and deq_ready=1 at full: one dequeue only, count=3.
- Drain order and wrap:
  - Stimulus: interleave enqueue/dequeue over 10 entries, pc 0x200+4k.
  - Required: deq_pc sequence is exactly 0x200, 0x204, … with no loss or duplication across pointer wrap; count constant while both handshakes fire.
- Flush with concurrent enqueue:
  - Stimulus: count=3, flush=1 together with enq_valid=1 (pc 0x300).
  - Required: deq_valid=0 and all fields 0 during that cycle; count=0 after the edge; 0x300 is not later dequeued.
- CSR field split:
  - Stimulus: enqueue 0x30029073 (csrw mstatus,t0).
  - Required: csr_addr=0x300, funct3=1, rs1=5, opcode=0x73, funct7=0x18.
- Reset mid-operation:
  - Stimulus: count=2 with enq_valid=1, deq_ready=1, then reset=1 for 1 cycle.
  - Required: count=0, deq_valid=0 next cycle; the next enqueue appears as the head one cycle later.
